// File: rtl/gray_bin_pipe.sv
// -----------------------------------------------------------------------------
// gray_bin_pipe
//
// Pipelined, bidirectional Gray <-> binary converter with valid/ready flow
// control. Each word carries its own mode bit, so words in the two directions
// can be mixed freely in one stream.
//
//   mode 0 : Gray -> binary. This is a prefix XOR running down from the MSB.
//            Stage s (0-based) resolves the next C = ceil(W/S) bits below the
//            bits already resolved, so each stage has a bounded XOR depth.
//   mode 1 : binary -> Gray (b ^ b>>1). This is done entirely in stage 0,
//            and the later stages pass the word through unchanged.
//
// Each stage keeps a single data word. In Gray->binary mode the bits above
// the resolved boundary already hold binary, and the bits below it still hold
// raw Gray. No separate copy of the Gray input is needed.
//
// Ports
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   flush      synchronous clear of every stage; blocks input that cycle
//   in_valid   / in_ready  / in_mode  / in_data   : input handshake + payload
//   out_valid  / out_ready / out_mode / out_data  : output handshake + payload
//   busy       any stage holds a valid word
// -----------------------------------------------------------------------------
module gray_bin_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int STAGES     = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_mode,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_mode,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy
);

  // Number of bits resolved per stage.
  localparam int C = (DATA_WIDTH + STAGES - 1) / STAGES;

  if (DATA_WIDTH < 1 || DATA_WIDTH > 64) begin : g_bad_width
    $error("gray_bin_pipe: DATA_WIDTH=%0d outside 1..64", DATA_WIDTH);
  end
  if (STAGES < 1 || STAGES > DATA_WIDTH) begin : g_bad_stages
    $error("gray_bin_pipe: STAGES=%0d outside 1..DATA_WIDTH", STAGES);
  end

  // Work done by stage s on the word it loads.
  // In Gray->binary mode, bit hi+1 is already binary (or hi is the MSB), so
  // walking downward gives bin[i] = gray[i] ^ bin[i+1] for i in [lo, hi].
  // If hi is below zero, the stage lies past bit 0 and passes the word through.
  function automatic logic [DATA_WIDTH-1:0] stage_conv(
    input int                    s,
    input logic                  mode,
    input logic [DATA_WIDTH-1:0] w
  );
    logic [DATA_WIDTH-1:0] r;
    int                    hi;
    int                    lo;
    r  = w;
    hi = DATA_WIDTH - 1 - s * C;
    lo = DATA_WIDTH - (s + 1) * C;
    if (lo < 0) lo = 0;
    if (mode) begin
      if (s == 0) r = w ^ (w >> 1);
    end else begin
      for (int i = DATA_WIDTH - 2; i >= 0; i--) begin
        if (i <= hi && i >= lo) r[i] = r[i] ^ r[i+1];
      end
    end
    return r;
  endfunction

  logic [STAGES-1:0]                 v_q, v_d;
  logic [STAGES-1:0]                 mode_q, mode_d;
  logic [STAGES-1:0][DATA_WIDTH-1:0] data_q, data_d;
  logic [STAGES-1:0]                 mv;      // stage s hands its word onward
  logic [STAGES-1:0]                 load;    // stage s may take a new word
  logic                              accept;

  // NOTE: every variable written here gets a default first, so that no path
  // leaves a value unassigned and no latch is inferred. Blocking assignments
  // are used because mv[s] reads the mv[s+1] value computed just above it.
  always_comb begin
    mv     = '0;
    load   = '0;
    v_d    = v_q;
    mode_d = mode_q;
    data_d = data_q;

    // Ready ripples back from the output, so a bubble anywhere in the
    // pipeline can be filled in the same cycle.
    mv[STAGES-1] = v_q[STAGES-1] & out_ready;
    for (int s = STAGES - 2; s >= 0; s--) begin
      mv[s] = v_q[s] & (~v_q[s+1] | mv[s+1]);
    end
    for (int s = 0; s < STAGES; s++) begin
      load[s] = ~v_q[s] | mv[s];
    end

    in_ready = load[0] & ~flush;
    accept   = in_valid & in_ready;

    if (load[0]) begin
      v_d[0] = accept;
      if (accept) begin
        mode_d[0] = in_mode;
        data_d[0] = stage_conv(0, in_mode, in_data);
      end
    end
    for (int s = 1; s < STAGES; s++) begin
      if (load[s]) begin
        v_d[s] = v_q[s-1];
        if (v_q[s-1]) begin
          mode_d[s] = mode_q[s-1];
          data_d[s] = stage_conv(s, mode_q[s-1], data_q[s-1]);
        end
      end
    end

    if (flush) v_d = '0;
  end

  // NOTE: the data and mode registers are reset together with the valid bits,
  // so that out_data and out_mode read as zero straight out of reset rather
  // than showing stale values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      v_q    <= '0;
      mode_q <= '0;
      data_q <= '0;
    end else begin
      v_q    <= v_d;
      mode_q <= mode_d;
      data_q <= data_d;
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign out_mode  = mode_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign busy      = |v_q;

endmodule

// File: tb/tb_gray_bin_pipe.sv
// -----------------------------------------------------------------------------
// tb_gray_bin_pipe
//
// Self-checking bench for gray_bin_pipe.
//   A (W4,S2), D (W4,S4), E (W4,S1) share one input stream of table vectors.
//     Each DUT is checked for its result, its mode and its exact latency.
//   B1 -> B2 (W16,S4) form a chain: binary->Gray, then Gray->binary.
//     All 65536 codes are sent through it, with a random out_ready at the
//     start. The Gray values between the two DUTs are also checked.
//   C (W16,S4) covers backpressure, flush and asynchronous reset mid-stream.
// -----------------------------------------------------------------------------
module tb_gray_bin_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference models, written as a plain prefix XOR so they do not follow
  // the staged structure of the RTL.
  function automatic logic [15:0] g2b(input logic [15:0] g);
    logic [15:0] b;
    b = g;
    for (int i = 1; i < 16; i++) b ^= (g >> i);
    return b;
  endfunction

  function automatic logic [15:0] b2g(input logic [15:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [16:0] ref17(input logic m, input logic [15:0] d);
    return {m, (m ? b2g(d) : g2b(d))};
  endfunction

  // ---------------- small 4-bit DUTs sharing one input stream ---------------
  logic       s_in_valid, s_in_mode, s_flush, s_out_ready;
  logic [3:0] s_in_data;
  logic       a_in_ready, a_out_valid, a_out_mode, a_busy;
  logic       d_in_ready, d_out_valid, d_out_mode, d_busy;
  logic       e_in_ready, e_out_valid, e_out_mode, e_busy;
  logic [3:0] a_out_data, d_out_data, e_out_data;

  gray_bin_pipe #(.DATA_WIDTH(4), .STAGES(2)) u_a (
    .clk(clk), .resetn(resetn), .flush(s_flush), .in_valid(s_in_valid),
    .in_ready(a_in_ready), .in_mode(s_in_mode), .in_data(s_in_data),
    .out_valid(a_out_valid), .out_ready(s_out_ready), .out_mode(a_out_mode),
    .out_data(a_out_data), .busy(a_busy));

  gray_bin_pipe #(.DATA_WIDTH(4), .STAGES(4)) u_d (
    .clk(clk), .resetn(resetn), .flush(s_flush), .in_valid(s_in_valid),
    .in_ready(d_in_ready), .in_mode(s_in_mode), .in_data(s_in_data),
    .out_valid(d_out_valid), .out_ready(s_out_ready), .out_mode(d_out_mode),
    .out_data(d_out_data), .busy(d_busy));

  gray_bin_pipe #(.DATA_WIDTH(4), .STAGES(1)) u_e (
    .clk(clk), .resetn(resetn), .flush(s_flush), .in_valid(s_in_valid),
    .in_ready(e_in_ready), .in_mode(s_in_mode), .in_data(s_in_data),
    .out_valid(e_out_valid), .out_ready(s_out_ready), .out_mode(e_out_mode),
    .out_data(e_out_data), .busy(e_busy));

  // ---------------- round-trip chain B1 -> B2 --------------------------------
  logic        b1_in_valid, b1_in_ready, b1_out_valid, b1_out_mode, b1_busy;
  logic [15:0] b1_in_data, b1_out_data;
  logic        b2_in_ready, b2_out_valid, b2_out_ready, b2_out_mode, b2_busy;
  logic [15:0] b2_out_data;

  gray_bin_pipe #(.DATA_WIDTH(16), .STAGES(4)) u_b1 (
    .clk(clk), .resetn(resetn), .flush(1'b0), .in_valid(b1_in_valid),
    .in_ready(b1_in_ready), .in_mode(1'b1), .in_data(b1_in_data),
    .out_valid(b1_out_valid), .out_ready(b2_in_ready), .out_mode(b1_out_mode),
    .out_data(b1_out_data), .busy(b1_busy));

  gray_bin_pipe #(.DATA_WIDTH(16), .STAGES(4)) u_b2 (
    .clk(clk), .resetn(resetn), .flush(1'b0), .in_valid(b1_out_valid),
    .in_ready(b2_in_ready), .in_mode(1'b0), .in_data(b1_out_data),
    .out_valid(b2_out_valid), .out_ready(b2_out_ready), .out_mode(b2_out_mode),
    .out_data(b2_out_data), .busy(b2_busy));

  // ---------------- flow-control DUT C ---------------------------------------
  logic        c_flush, c_in_valid, c_in_ready, c_in_mode;
  logic        c_out_valid, c_out_ready, c_out_mode, c_busy;
  logic [15:0] c_in_data, c_out_data;

  gray_bin_pipe #(.DATA_WIDTH(16), .STAGES(4)) u_c (
    .clk(clk), .resetn(resetn), .flush(c_flush), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .in_mode(c_in_mode), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_mode(c_out_mode),
    .out_data(c_out_data), .busy(c_busy));

  // ---------------- vector table ---------------------------------------------
  typedef struct {
    logic       mode;
    logic [3:0] data;
    logic [3:0] exp;
  } vec_t;

  localparam int NV = 12;
  vec_t tab [NV];
  int   acc_cyc [NV];

  // Checks one small DUT's output against the next expected table row.
  task automatic chk_small(input string n, input logic v, input logic m,
                           input logic [3:0] d, input int lat, inout int rd);
    if (v) begin
      if (rd < NV) begin
        check({n, "_data"}, d, tab[rd].exp);
        check({n, "_mode"}, m, tab[rd].mode);
        check({n, "_lat"}, cyc - acc_cyc[rd], lat);
      end else begin
        check({n, "_extra_out"}, v, 1'b0);
      end
      rd++;
    end
  endtask

  // C scoreboard: {mode, data} expected at the output, in order.
  logic [16:0] cq [$];
  int          c_acc = 0;

  // Call just after driving C's inputs at a negedge. Evaluates both
  // handshakes as they will fire at the next posedge, then advances a cycle.
  task automatic c_step();
    #1;
    if (c_out_valid) begin
      if (cq.size() == 0) check("c_unexpected_out", c_out_valid, 1'b0);
      else begin
        check("c_out", {c_out_mode, c_out_data}, cq[0]);
        if (c_out_ready) void'(cq.pop_front());
      end
    end
    if (c_in_valid && c_in_ready) begin
      cq.push_back(ref17(c_in_mode, c_in_data));
      c_acc++;
    end
    @(negedge clk);
  endtask

  task automatic c_drain(input string n);
    c_in_valid = 1'b0;
    c_out_ready = 1'b1;
    for (int i = 0; i < 12 && (cq.size() != 0 || c_out_valid); i++) c_step();
    check({n, "_left"}, cq.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ra, rd, re;
    int nx, nr;
    logic [15:0] q1 [$];
    logic [15:0] q2 [$];
    logic [15:0] x;

    tab[0]  = '{1'b0, 4'b0110, 4'b0100};
    tab[1]  = '{1'b1, 4'b1011, 4'b1110};
    tab[2]  = '{1'b0, 4'b0000, 4'b0000};
    tab[3]  = '{1'b1, 4'b0000, 4'b0000};
    tab[4]  = '{1'b0, 4'b1000, 4'b1111};
    tab[5]  = '{1'b1, 4'b1111, 4'b1000};
    tab[6]  = '{1'b0, 4'b1111, 4'b1010};
    tab[7]  = '{1'b1, 4'b1010, 4'b1111};
    tab[8]  = '{1'b0, 4'b0001, 4'b0001};
    tab[9]  = '{1'b1, 4'b0111, 4'b0100};
    tab[10] = '{1'b0, 4'b1101, 4'b1001};
    tab[11] = '{1'b1, 4'b1001, 4'b1101};

    s_in_valid = 0; s_in_mode = 0; s_in_data = '0; s_flush = 0; s_out_ready = 1;
    b1_in_valid = 0; b1_in_data = '0; b2_out_ready = 0;
    c_flush = 0; c_in_valid = 0; c_in_mode = 0; c_in_data = '0; c_out_ready = 0;

    // ---- reset state ----
    resetn = 1'b1;
    #2 resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_a_valid", a_out_valid, 1'b0);
    check("rst_a_data", a_out_data, 4'h0);
    check("rst_a_busy", a_busy, 1'b0);
    check("rst_c_valid", c_out_valid, 1'b0);
    check("rst_c_data", c_out_data, 16'h0);
    check("rst_c_mode", c_out_mode, 1'b0);
    check("rst_c_busy", c_busy, 1'b0);
    resetn = 1'b1;
    @(negedge clk);

    // ---- table vectors, back-to-back, modes alternating ----
    ra = 0; rd = 0; re = 0;
    for (int t = 0; t < NV + 6; t++) begin
      s_in_valid = (t < NV);
      if (t < NV) begin
        s_in_mode = tab[t].mode;
        s_in_data = tab[t].data;
      end
      #1;
      if (s_in_valid) begin
        check("a_in_ready", a_in_ready, 1'b1);
        acc_cyc[t] = cyc;
      end
      chk_small("a", a_out_valid, a_out_mode, a_out_data, 2, ra);
      chk_small("d", d_out_valid, d_out_mode, d_out_data, 4, rd);
      chk_small("e", e_out_valid, e_out_mode, e_out_data, 1, re);
      @(negedge clk);
    end
    check("a_count", ra, NV);
    check("d_count", rd, NV);
    check("e_count", re, NV);

    // ---- full 16-bit round trip through B1 -> B2 ----
    nx = 0; nr = 0;
    for (int it = 0; it < 70000 && nr < 65536; it++) begin
      b1_in_valid  = (nx < 65536);
      b1_in_data   = nx[15:0];
      b2_out_ready = (nx < 1024) ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (b2_out_valid && b2_out_ready) begin
        x = (q2.size() > 0) ? q2.pop_front() : 16'hxxxx;
        check("roundtrip", {b2_out_mode, b2_out_data}, {1'b0, x});
        nr++;
      end
      if (b1_out_valid && b2_in_ready) begin
        x = (q1.size() > 0) ? q1.pop_front() : 16'hxxxx;
        check("bin2gray", {b1_out_mode, b1_out_data}, {1'b1, b2g(x)});
        q2.push_back(x);
      end
      if (b1_in_valid && b1_in_ready) begin
        q1.push_back(nx[15:0]);
        nx++;
      end
      @(negedge clk);
    end
    b1_in_valid = 1'b0;
    check("roundtrip_count", nr, 65536);

    // ---- backpressure: 10 cycles offered, out_ready low ----
    c_out_ready = 1'b0;
    c_acc = 0;
    for (int i = 0; i < 10; i++) begin
      c_in_valid = 1'b1;
      c_in_mode  = i[0];
      c_in_data  = 16'hA5F0 + 16'(i) * 16'h0111;
      c_step();
    end
    check("bp_accepted", c_acc, 4);
    check("bp_in_ready", c_in_ready, 1'b0);
    check("bp_busy", c_busy, 1'b1);
    // Release: while full, an accept and an emit happen in the same cycle.
    c_out_ready = 1'b1;
    c_in_data = 16'h1234;
    c_in_mode = 1'b0;
    #1 check("bp_full_thru", c_in_ready, 1'b1);
    c_step();
    for (int i = 0; i < 5; i++) begin
      c_in_mode = i[0];
      c_in_data = 16'h8001 ^ (16'(i) << 4);
      c_step();
    end
    c_drain("bp");
    check("bp_total_acc", c_acc, 10);
    check("bp_idle_busy", c_busy, 1'b0);

    // ---- flush with 3 words in flight ----
    c_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      c_in_valid = 1'b1;
      c_in_mode  = 1'b0;
      c_in_data  = 16'h0F00 + 16'(i);
      c_step();
    end
    c_flush = 1'b1;
    c_in_data = 16'hDEAD;
    #1;
    check("flush_in_ready", c_in_ready, 1'b0);
    check("flush_busy_before", c_busy, 1'b1);
    @(negedge clk);
    c_flush = 1'b0;
    c_in_valid = 1'b0;
    #1;
    check("flush_busy_after", c_busy, 1'b0);
    check("flush_out_valid", c_out_valid, 1'b0);
    cq.delete();
    @(negedge clk);
    c_out_ready = 1'b1;
    c_in_valid = 1'b1;
    c_in_mode = 1'b0;
    c_in_data = 16'h8000;
    c_step();
    c_drain("post_flush");

    // ---- asynchronous reset mid-stream ----
    c_out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      c_in_valid = 1'b1;
      c_in_mode  = i[1];
      c_in_data  = 16'h3C00 + 16'(i) * 16'h0013;
      c_step();
    end
    @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    check("arst_out_valid", c_out_valid, 1'b0);
    check("arst_busy", c_busy, 1'b0);
    check("arst_out_data", c_out_data, 16'h0);
    @(negedge clk);
    c_in_valid = 1'b0;
    cq.delete();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 resetn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) c_step();
    check("arst_no_stale", c_busy, 1'b0);
    c_in_valid = 1'b1;
    c_in_mode = 1'b1;
    c_in_data = 16'hFFFF;
    c_step();
    c_drain("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
